// File: rtl/fp_op_arb_resp_pkg.sv
// Shared helpers for the field-op arbiter: initiator-ID field width and get/set of
// the ID field inside a control tag (tags up to 64 bits wide).
package fp_op_arb_resp_pkg;

  localparam int CTL_MAX_BITS = 64;

  function automatic int calc_id_bits(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [CTL_MAX_BITS-1:0] get_id(input logic [CTL_MAX_BITS-1:0] ctl,
                                                     input int lsb, input int w);
    logic [CTL_MAX_BITS-1:0] mask;
    mask = (64'd1 << w) - 64'd1;
    return (ctl >> lsb) & mask;
  endfunction

  function automatic logic [CTL_MAX_BITS-1:0] set_id(input logic [CTL_MAX_BITS-1:0] ctl,
                                                     input int lsb, input int w,
                                                     input logic [CTL_MAX_BITS-1:0] id);
    logic [CTL_MAX_BITS-1:0] mask;
    mask = ((64'd1 << w) - 64'd1) << lsb;
    return (ctl & ~mask) | ((id << lsb) & mask);
  endfunction

endpackage

// File: rtl/fp_op_rr_arb.sv
// Request-vector arbiter producing a one-hot grant and its index.
// FP_OP_ARB_RR_EN: round-robin from the index after the last grant; otherwise lowest index wins.
module fp_op_rr_arb
  import fp_op_arb_resp_pkg::*;
#(
  parameter int NUM_IN = 2,
  localparam int ID_BITS = calc_id_bits(NUM_IN)
) (
`ifdef FP_OP_ARB_RR_EN
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               adv,
`endif
  input  logic [NUM_IN-1:0]  req,
  output logic [NUM_IN-1:0]  grant,
  output logic [ID_BITS-1:0] gidx
);

  int   idx;
  logic found;

`ifdef FP_OP_ARB_RR_EN
  logic [ID_BITS-1:0] ptr;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      ptr <= '0;
    end else if (adv) begin
      ptr <= (int'(gidx) == NUM_IN - 1) ? '0 : gidx + 1'b1;
    end
  end
`endif

  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_IN; k++) begin
`ifdef FP_OP_ARB_RR_EN
      idx = (int'(ptr) + k) % NUM_IN;
`else
      idx = k;
`endif
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        gidx       = ID_BITS'(idx);
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_op_arb_resp.sv
// Shares one field-arithmetic unit among NUM_IN initiators: arbitrated request slot,
// ID-tagged routing of results back. FP_OP_ARB_RR_EN selects round-robin arbitration.
module fp_op_arb_resp
  import fp_op_arb_resp_pkg::*;
#(
  parameter int NUM_IN      = 2,
  parameter int DAT_BITS    = 381,
  parameter int CTL_BITS    = 16,
  parameter int OVR_WRT_BIT = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [NUM_IN*2*DAT_BITS-1:0] i_req_dat,
  input  logic [NUM_IN*CTL_BITS-1:0]   i_req_ctl,
  input  logic [NUM_IN-1:0]            i_req_val,
  output logic [NUM_IN-1:0]            o_req_rdy,
  output logic [NUM_IN*DAT_BITS-1:0]   o_res_dat,
  output logic [NUM_IN*CTL_BITS-1:0]   o_res_ctl,
  output logic [NUM_IN-1:0]            o_res_val,
  input  logic [NUM_IN-1:0]            i_res_rdy,
  output logic [2*DAT_BITS-1:0]        o_unit_dat,
  output logic [CTL_BITS-1:0]          o_unit_ctl,
  output logic                         o_unit_val,
  input  logic                         i_unit_rdy,
  input  logic [DAT_BITS-1:0]          i_unit_dat,
  input  logic [CTL_BITS-1:0]          i_unit_ctl,
  input  logic                         i_unit_val,
  output logic                         o_unit_rdy,
  output logic                         o_err,
  output logic                         o_busy
);

  localparam int ID_BITS = calc_id_bits(NUM_IN);

  logic                  slot_val;
  logic [2*DAT_BITS-1:0] slot_dat;
  logic [CTL_BITS-1:0]   slot_ctl;
  logic [7:0]            cnt, cnt_nxt;
  logic [NUM_IN-1:0]     grant;
  logic [ID_BITS-1:0]    gidx;
  logic                  unit_req_acc, unit_rsp_acc, load_ok, slot_load;
  logic [2*DAT_BITS-1:0] sel_dat;
  logic [CTL_BITS-1:0]   sel_ctl;
  logic [ID_BITS-1:0]    rid;
  logic                  rid_bad, tgt_free;
  logic [NUM_IN-1:0]     res_val;
  logic [DAT_BITS-1:0]   res_dat [NUM_IN];
  logic [CTL_BITS-1:0]   res_ctl [NUM_IN];
  logic                  err_q;

  assign o_unit_val   = slot_val & i_rst;
  assign o_unit_dat   = slot_dat;
  assign o_unit_ctl   = slot_ctl;
  assign unit_req_acc = o_unit_val & i_unit_rdy;

  always_comb begin
    cnt_nxt = cnt;
    if (unit_req_acc && !unit_rsp_acc) begin
      cnt_nxt = cnt + 8'd1;
    end else if (!unit_req_acc && unit_rsp_acc && cnt != 8'd0) begin
      cnt_nxt = cnt - 8'd1;
    end
  end

  // A new load only when the counter can still absorb its eventual issue.
  assign load_ok   = i_rst & (~slot_val | unit_req_acc) & (cnt_nxt != 8'hFF);
  assign slot_load = load_ok & (|i_req_val);
  assign o_req_rdy = grant & {NUM_IN{load_ok}};

  fp_op_rr_arb #(.NUM_IN(NUM_IN)) u_arb (
`ifdef FP_OP_ARB_RR_EN
    .i_clk (i_clk),
    .i_rst (i_rst),
    .adv   (slot_load),
`endif
    .req   (i_req_val),
    .grant (grant),
    .gidx  (gidx)
  );

  always_comb begin
    sel_dat = '0;
    sel_ctl = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (grant[k]) begin
        sel_dat = sel_dat | i_req_dat[k*2*DAT_BITS +: 2*DAT_BITS];
        sel_ctl = sel_ctl | i_req_ctl[k*CTL_BITS +: CTL_BITS];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      slot_val <= 1'b0;
    end else if (slot_load) begin
      slot_val <= 1'b1;
    end else if (unit_req_acc) begin
      slot_val <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (slot_load) begin
      slot_dat <= sel_dat;
      slot_ctl <= CTL_BITS'(set_id(64'(sel_ctl), OVR_WRT_BIT, ID_BITS, 64'(gidx)));
    end
  end

  assign rid     = ID_BITS'(get_id(64'(i_unit_ctl), OVR_WRT_BIT, ID_BITS));
  assign rid_bad = (32'(rid) >= NUM_IN);

  always_comb begin
    tgt_free = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (rid == ID_BITS'(k)) tgt_free = ~res_val[k] | i_res_rdy[k];
    end
  end

  // Misrouted responses are always taken so a bad tag cannot wedge the unit.
  assign o_unit_rdy   = i_rst & (rid_bad | tgt_free);
  assign unit_rsp_acc = i_unit_val & o_unit_rdy;

  always_ff @(posedge i_clk) begin
    for (int k = 0; k < NUM_IN; k++) begin
      if (!i_rst) begin
        res_val[k] <= 1'b0;
      end else if (unit_rsp_acc && !rid_bad && rid == ID_BITS'(k)) begin
        res_val[k] <= 1'b1;
      end else if (i_res_rdy[k]) begin
        res_val[k] <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    for (int k = 0; k < NUM_IN; k++) begin
      if (unit_rsp_acc && !rid_bad && rid == ID_BITS'(k)) begin
        res_dat[k] <= i_unit_dat;
        res_ctl[k] <= CTL_BITS'(set_id(64'(i_unit_ctl), OVR_WRT_BIT, ID_BITS, 64'd0));
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      err_q <= 1'b0;
      cnt   <= 8'd0;
    end else begin
      err_q <= unit_rsp_acc & rid_bad;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    o_res_dat = '0;
    o_res_ctl = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      o_res_dat[k*DAT_BITS +: DAT_BITS] = res_dat[k];
      o_res_ctl[k*CTL_BITS +: CTL_BITS] = res_ctl[k];
    end
  end

  assign o_res_val = res_val & {NUM_IN{i_rst}};
  assign o_err     = err_q & i_rst;
  assign o_busy    = i_rst & (slot_val | (|res_val) | (cnt != 8'd0));

endmodule

// File: tb/tb_fp_op_arb_resp.sv
// Directed bench for fp_op_arb_resp with a modular-adder unit model; NUM_IN=3 so that
// an out-of-range ID (3) is representable in the 2-bit ID field.
module tb_fp_op_arb_resp;

  localparam int NI = 3;
  localparam int DB = 16;
  localparam int CB = 16;
  localparam int OB = 8;
  localparam logic [31:0] P = 32'd65521;

  logic             i_clk = 1'b0;
  logic             i_rst = 1'b0;
  logic [NI*2*DB-1:0] i_req_dat = '0;
  logic [NI*CB-1:0] i_req_ctl = '0;
  logic [NI-1:0]    i_req_val = '0;
  logic [NI-1:0]    o_req_rdy;
  logic [NI*DB-1:0] o_res_dat;
  logic [NI*CB-1:0] o_res_ctl;
  logic [NI-1:0]    o_res_val;
  logic [NI-1:0]    i_res_rdy = '0;
  logic [2*DB-1:0]  o_unit_dat;
  logic [CB-1:0]    o_unit_ctl;
  logic             o_unit_val;
  logic             i_unit_rdy = 1'b0;
  logic [DB-1:0]    i_unit_dat;
  logic [CB-1:0]    i_unit_ctl;
  logic             i_unit_val;
  logic             o_unit_rdy;
  logic             o_err, o_busy;

  logic             resp_en = 1'b0;
  logic             man_val = 1'b0, mdl_val = 1'b0;
  logic [DB-1:0]    man_dat = '0, mdl_dat = '0;
  logic [CB-1:0]    man_ctl = '0, mdl_ctl = '0;

  assign i_unit_val = resp_en ? mdl_val : man_val;
  assign i_unit_dat = resp_en ? mdl_dat : man_dat;
  assign i_unit_ctl = resp_en ? mdl_ctl : man_ctl;

  typedef struct {
    logic [DB-1:0] d;
    logic [CB-1:0] c;
  } rsp_t;

  rsp_t          q[$];
  logic [CB-1:0] ctl_log[$];
  int            dcount[NI];
  int            n_chk = 0;
  int            n_err = 0;

  always #5 i_clk = ~i_clk;

  fp_op_arb_resp #(.NUM_IN(NI), .DAT_BITS(DB), .CTL_BITS(CB), .OVR_WRT_BIT(OB)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_dat(i_req_dat), .i_req_ctl(i_req_ctl), .i_req_val(i_req_val), .o_req_rdy(o_req_rdy),
    .o_res_dat(o_res_dat), .o_res_ctl(o_res_ctl), .o_res_val(o_res_val), .i_res_rdy(i_res_rdy),
    .o_unit_dat(o_unit_dat), .o_unit_ctl(o_unit_ctl), .o_unit_val(o_unit_val), .i_unit_rdy(i_unit_rdy),
    .i_unit_dat(i_unit_dat), .i_unit_ctl(i_unit_ctl), .i_unit_val(i_unit_val), .o_unit_rdy(o_unit_rdy),
    .o_err(o_err), .o_busy(o_busy)
  );

  // Unit model: (a + b) mod P, in order, tag returned untouched.
  always @(posedge i_clk) begin
    logic [31:0] s;
    if (resp_en && i_unit_val && o_unit_rdy) void'(q.pop_front());
    if (o_unit_val && i_unit_rdy) begin
      s = (32'(o_unit_dat[DB-1:0]) + 32'(o_unit_dat[2*DB-1:DB])) % P;
      q.push_back('{d: s[DB-1:0], c: o_unit_ctl});
      ctl_log.push_back(o_unit_ctl);
    end
    for (int k = 0; k < NI; k++) begin
      if (o_res_val[k] && i_res_rdy[k]) dcount[k]++;
    end
  end

  always @(negedge i_clk) begin
    mdl_val = (q.size() > 0);
    if (q.size() > 0) begin
      mdl_dat = q[0].d;
      mdl_ctl = q[0].c;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int k, input logic [DB-1:0] a, input logic [DB-1:0] b,
                         input logic [CB-1:0] ctl);
    i_req_dat[k*2*DB +: 2*DB] = {b, a};
    i_req_ctl[k*CB +: CB]     = ctl;
  endtask

  initial begin
    int base0, base1, base2, hi, n;
    logic [NI-1:0] exp_g;

    // Reset state, with requests already asserted.
    i_req_val = 3'b011;
    repeat (2) @(negedge i_clk);
    #1;
    check_val("rst_unit_val", o_unit_val, 0);
    check_val("rst_res_val", o_res_val, 0);
    check_val("rst_req_rdy", o_req_rdy, 0);
    check_val("rst_err", o_err, 0);
    check_val("rst_busy", o_busy, 0);
    @(negedge i_clk);
    i_rst = 1'b1;
    i_req_val = '0;

    // Single request from initiator 1: 5 + 7.
    @(negedge i_clk);
    resp_en = 1'b1;
    i_unit_rdy = 1'b1;
    i_res_rdy = 3'b101;
    ctl_log.delete();
    set_req(1, 16'd5, 16'd7, 16'h0003);
    i_req_val = 3'b010;
    #1;
    check_val("single_rdy", o_req_rdy, 3'b010);
    @(negedge i_clk);
    i_req_val = '0;
    n = 0;
    while (n < 20 && !o_res_val[1]) begin
      @(negedge i_clk);
      n++;
    end
    #1;
    check_val("single_val", o_res_val[1], 1);
    check_val("single_dat", o_res_dat[1*DB +: DB], 16'd12);
    check_val("single_ctl", o_res_ctl[1*CB +: CB], 16'h0003);
    check_val("single_uctl", (ctl_log.size() > 0) ? ctl_log[0] : 16'hxxxx, 16'h0103);
    check_val("single_busy", o_busy, 1);
    i_res_rdy = 3'b111;
    @(negedge i_clk);
    #1;
    check_val("single_done", o_busy, 0);

    // Both initiators requesting continuously.
    base0 = dcount[0];
    base1 = dcount[1];
    set_req(0, 16'd1, 16'd2, 16'h0000);
    set_req(1, 16'd10, 16'd20, 16'h0000);
    i_req_val = 3'b011;
    for (int i = 0; i < 4; i++) begin
      #1;
`ifdef FP_OP_ARB_RR_EN
      exp_g = (i % 2 == 0) ? 3'b001 : 3'b010;
`else
      exp_g = 3'b001;
`endif
      check_val($sformatf("grant_%0d", i), o_req_rdy, exp_g);
      @(negedge i_clk);
    end
    i_req_val = '0;
    n = 0;
    while (n < 30 && o_busy) begin
      @(negedge i_clk);
      n++;
    end
    check_val("both_idle", o_busy, 0);
`ifdef FP_OP_ARB_RR_EN
    check_val("both_del0", dcount[0] - base0, 2);
    check_val("both_del1", dcount[1] - base1, 2);
`else
    check_val("both_del0", dcount[0] - base0, 4);
    check_val("both_del1", dcount[1] - base1, 0);
`endif

    // Back-pressure on initiator 0 must not block initiator 1.
    resp_en = 1'b0;
    i_res_rdy = 3'b110;
    man_val = 1'b1;
    man_ctl = 16'h0011;
    man_dat = 16'hAAAA;
    #1;
    check_val("bp_first_rdy", o_unit_rdy, 1);
    @(negedge i_clk);
    man_dat = 16'hBBBB;
    man_ctl = 16'h0022;
    #1;
    check_val("bp_hold_val", o_res_val[0], 1);
    check_val("bp_hold_dat", o_res_dat[0 +: DB], 16'hAAAA);
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (o_unit_rdy) hi++;
      @(negedge i_clk);
    end
    check_val("bp_rdy_low", hi, 0);
    man_ctl = 16'h0133;
    man_dat = 16'hCCCC;
    #1;
    check_val("bp_id1_rdy", o_unit_rdy, 1);
    @(negedge i_clk);
    man_ctl = 16'h0022;
    man_dat = 16'hBBBB;
    i_res_rdy = 3'b111;
    #1;
    check_val("bp_id1_val", o_res_val[1], 1);
    check_val("bp_id1_dat", o_res_dat[1*DB +: DB], 16'hCCCC);
    check_val("bp_id1_ctl", o_res_ctl[1*CB +: CB], 16'h0033);
    check_val("bp_drain_rdy", o_unit_rdy, 1);
    @(negedge i_clk);
    man_val = 1'b0;
    #1;
    check_val("bp_id0_dat", o_res_dat[0 +: DB], 16'hBBBB);
    @(negedge i_clk);
    #1;
    check_val("bp_no_underflow", o_busy, 0);

    // Misrouted response, ID 3.
    man_val = 1'b1;
    man_ctl = 16'h0305;
    man_dat = 16'h1234;
    #1;
    check_val("err_rdy", o_unit_rdy, 1);
    @(negedge i_clk);
    man_val = 1'b0;
    #1;
    check_val("err_pulse", o_err, 1);
    check_val("err_no_val", o_res_val, 0);
    @(negedge i_clk);
    #1;
    check_val("err_one_cycle", o_err, 0);

    // Reset with three in flight and one buffered.
    base2 = dcount[2];
    i_unit_rdy = 1'b1;
    set_req(2, 16'd3, 16'd4, 16'h00F0);
    i_req_val = 3'b100;
    repeat (4) @(negedge i_clk);
    i_req_val = '0;
    i_unit_rdy = 1'b0;
    #1;
    check_val("fl_count", q.size(), 3);
    check_val("fl_busy", o_busy, 1);
    check_val("fl_slot", o_unit_val, 1);
    i_rst = 1'b0;
    i_req_val = 3'b111;
    #1;
    check_val("mrst_unit_val", o_unit_val, 0);
    check_val("mrst_busy", o_busy, 0);
    check_val("mrst_req_rdy", o_req_rdy, 0);
    @(negedge i_clk);
    i_rst = 1'b1;
    i_req_val = '0;
    #1;
    check_val("post_rst_busy", o_busy, 0);
    check_val("post_rst_slot", o_unit_val, 0);
    resp_en = 1'b1;
    i_unit_rdy = 1'b1;
    n = 0;
    while (n < 40 && (q.size() != 0 || o_busy)) begin
      @(negedge i_clk);
      n++;
    end
    #1;
    check_val("late_del", dcount[2] - base2, 3);
    check_val("late_dat", o_res_dat[2*DB +: DB], 16'd7);
    check_val("late_busy", o_busy, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
